// File: rtl/warp_fetcher.sv
// Fetch stage: per-warp PC/mask table with a round-robin pick of one READY warp per cycle into a registered request.
// Launch to fe_valid_o takes two edges; the request holds steady while ic_ready_i is low and refills back-to-back.
module warp_fetcher #(
   parameter int PcWidth   = 32,
   parameter int NumWarps  = 8,
   parameter int WarpWidth = 32,
   parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 launch_valid_i,
   output logic                 launch_ready_o,
   input  logic [WidWidth-1:0]  launch_wid_i,
   input  logic [PcWidth-1:0]   launch_pc_i,
   input  logic [WarpWidth-1:0] launch_act_mask_i,

   input  logic [NumWarps-1:0]  ib_space_i,

   input  logic                 ic_ready_i,
   output logic                 fe_valid_o,
   output logic [PcWidth-1:0]   fe_pc_o,
   output logic [WarpWidth-1:0] fe_act_mask_o,
   output logic [WidWidth-1:0]  fe_warp_id_o,

   input  logic                 upd_valid_i,
   input  logic [WidWidth-1:0]  upd_wid_i,
   input  logic [PcWidth-1:0]   upd_pc_i,
   input  logic [WarpWidth-1:0] upd_act_mask_i,
   input  logic                 upd_exit_i,

   output logic                 busy_o
);

   typedef enum logic [1:0] {
      ST_INACTIVE = 2'd0,
      ST_READY    = 2'd1,
      ST_WAITING  = 2'd2
   } wstate_e;

   wstate_e              st_q   [NumWarps];
   wstate_e              st_d   [NumWarps];
   logic [PcWidth-1:0]   pc_q   [NumWarps];
   logic [PcWidth-1:0]   pc_d   [NumWarps];
   logic [WarpWidth-1:0] mask_q [NumWarps];
   logic [WarpWidth-1:0] mask_d [NumWarps];

   logic [WidWidth-1:0]  rr_q, rr_d;

   logic                 fe_vld_q,  fe_vld_d;
   logic [PcWidth-1:0]   fe_pc_q,   fe_pc_d;
   logic [WarpWidth-1:0] fe_mask_q, fe_mask_d;
   logic [WidWidth-1:0]  fe_wid_q,  fe_wid_d;

   logic [NumWarps-1:0]  elig;
   logic                 win_found;
   logic [WidWidth-1:0]  win_wid;
   logic                 load_en;
   logic                 launch_fire;
   logic                 upd_fire;
   logic                 upd_retire;
   logic                 busy;

   assign launch_ready_o = (st_q[launch_wid_i] == ST_INACTIVE);
   assign launch_fire    = launch_valid_i && launch_ready_o;
   assign upd_fire       = upd_valid_i && (st_q[upd_wid_i] == ST_WAITING);
   assign upd_retire     = upd_exit_i || (upd_act_mask_i == '0);
   // Refill decision looks only at registered valid, so fe_valid_o never follows ic_ready_i combinationally.
   assign load_en        = !fe_vld_q || ic_ready_i;

   always_comb begin
      elig = '0;
      for (int w = 0; w < NumWarps; w++) begin
         elig[w] = (st_q[w] == ST_READY) && ib_space_i[w];
      end
   end

   // Scan starts at the round-robin pointer and wraps; first eligible warp wins.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_wid   = '0;
      for (int k = 0; k < NumWarps; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NumWarps) begin
            idx = idx - NumWarps;
         end
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_wid   = WidWidth'(idx);
         end
      end
   end

   always_comb begin
      st_d      = st_q;
      pc_d      = pc_q;
      mask_d    = mask_q;
      rr_d      = rr_q;
      fe_vld_d  = fe_vld_q;
      fe_pc_d   = fe_pc_q;
      fe_mask_d = fe_mask_q;
      fe_wid_d  = fe_wid_q;

      if (launch_fire) begin
         st_d[launch_wid_i]   = ST_READY;
         pc_d[launch_wid_i]   = launch_pc_i;
         mask_d[launch_wid_i] = launch_act_mask_i;
      end

      if (upd_fire) begin
         st_d[upd_wid_i]   = upd_retire ? ST_INACTIVE : ST_READY;
         pc_d[upd_wid_i]   = upd_pc_i;
         mask_d[upd_wid_i] = upd_act_mask_i;
      end

      // Launch and update only touch non-READY warps, so the winner's table entry is unaffected this cycle.
      if (load_en) begin
         if (win_found) begin
            fe_vld_d      = 1'b1;
            fe_pc_d       = pc_q[win_wid];
            fe_mask_d     = mask_q[win_wid];
            fe_wid_d      = win_wid;
            st_d[win_wid] = ST_WAITING;
            rr_d          = (win_wid == WidWidth'(NumWarps - 1)) ? '0 : win_wid + WidWidth'(1);
         end else begin
            fe_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int w = 0; w < NumWarps; w++) begin
            st_q[w]   <= ST_INACTIVE;
            pc_q[w]   <= '0;
            mask_q[w] <= '0;
         end
         rr_q      <= '0;
         fe_vld_q  <= 1'b0;
         fe_pc_q   <= '0;
         fe_mask_q <= '0;
         fe_wid_q  <= '0;
      end else begin
         st_q      <= st_d;
         pc_q      <= pc_d;
         mask_q    <= mask_d;
         rr_q      <= rr_d;
         fe_vld_q  <= fe_vld_d;
         fe_pc_q   <= fe_pc_d;
         fe_mask_q <= fe_mask_d;
         fe_wid_q  <= fe_wid_d;
      end
   end

   always_comb begin
      busy = fe_vld_q;
      for (int w = 0; w < NumWarps; w++) begin
         if (st_q[w] != ST_INACTIVE) begin
            busy = 1'b1;
         end
      end
   end

   assign busy_o        = busy;
   assign fe_valid_o    = fe_vld_q;
   assign fe_pc_o       = fe_pc_q;
   assign fe_act_mask_o = fe_mask_q;
   assign fe_warp_id_o  = fe_wid_q;

   // Decode must only return a next PC for a warp it was handed; anything else is dropped.
   upd_targets_waiting_a : assert property (@(posedge clk_i) disable iff (rst_i)
      upd_valid_i |-> (st_q[upd_wid_i] == ST_WAITING))
      else $warning("warp_fetcher: update to warp %0d dropped, warp not waiting", upd_wid_i);

endmodule

// File: tb/tb_warp_fetcher.sv
// Randomized and directed bench for warp_fetcher against a queue/array model of the per-warp rules.
module tb_warp_fetcher;

   logic        clk;
   logic        rst;
   logic        launch_valid;
   logic        launch_ready;
   logic [2:0]  launch_wid;
   logic [31:0] launch_pc;
   logic [31:0] launch_mask;
   logic [7:0]  ib_space;
   logic        ic_ready;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic [31:0] fe_mask;
   logic [2:0]  fe_wid;
   logic        upd_valid;
   logic [2:0]  upd_wid;
   logic [31:0] upd_pc;
   logic [31:0] upd_mask;
   logic        upd_exit;
   logic        busy;

   warp_fetcher dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .launch_valid_i    (launch_valid),
      .launch_ready_o    (launch_ready),
      .launch_wid_i      (launch_wid),
      .launch_pc_i       (launch_pc),
      .launch_act_mask_i (launch_mask),
      .ib_space_i        (ib_space),
      .ic_ready_i        (ic_ready),
      .fe_valid_o        (fe_valid),
      .fe_pc_o           (fe_pc),
      .fe_act_mask_o     (fe_mask),
      .fe_warp_id_o      (fe_wid),
      .upd_valid_i       (upd_valid),
      .upd_wid_i         (upd_wid),
      .upd_pc_i          (upd_pc),
      .upd_act_mask_i    (upd_mask),
      .upd_exit_i        (upd_exit),
      .busy_o            (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int dut_grants[$];

   // Model: warp state 0=inactive 1=ready 2=waiting, plus the one-entry request slot.
   int          m_st   [8];
   logic [31:0] m_pc   [8];
   logic [31:0] m_mask [8];
   int          m_rr;
   bit          m_vld;
   logic [31:0] m_fpc;
   logic [31:0] m_fmask;
   int          m_fwid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      bit b;
      b = m_vld;
      for (int w = 0; w < 8; w++) if (m_st[w] != 0) b = 1'b1;
      return b;
   endfunction

   task automatic model_edge();
      int          nst   [8];
      logic [31:0] npc   [8];
      logic [31:0] nmask [8];
      int          win;
      int          w;
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_st[i] = 0; m_pc[i] = '0; m_mask[i] = '0;
         end
         m_rr = 0; m_vld = 1'b0; m_fpc = '0; m_fmask = '0; m_fwid = 0;
         return;
      end
      nst = m_st; npc = m_pc; nmask = m_mask;
      if (launch_valid && m_st[launch_wid] == 0) begin
         nst[launch_wid] = 1; npc[launch_wid] = launch_pc; nmask[launch_wid] = launch_mask;
      end
      if (upd_valid && m_st[upd_wid] == 2) begin
         nst[upd_wid]   = (upd_exit || upd_mask == 0) ? 0 : 1;
         npc[upd_wid]   = upd_pc;
         nmask[upd_wid] = upd_mask;
      end
      if (!m_vld || ic_ready) begin
         win = -1;
         for (int k = 0; k < 8; k++) begin
            w = (m_rr + k) % 8;
            if (win < 0 && m_st[w] == 1 && ib_space[w]) win = w;
         end
         if (win >= 0) begin
            m_vld = 1'b1; m_fpc = m_pc[win]; m_fmask = m_mask[win]; m_fwid = win;
            nst[win] = 2;
            m_rr = (win + 1) % 8;
         end else begin
            m_vld = 1'b0;
         end
      end
      m_st = nst; m_pc = npc; m_mask = nmask;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("fe_valid", 32'(fe_valid), 32'(m_vld));
         if (m_vld) begin
            chk("fe_pc", fe_pc, m_fpc);
            chk("fe_mask", fe_mask, m_fmask);
            chk("fe_wid", 32'(fe_wid), 32'(m_fwid));
         end
         chk("launch_ready", 32'(launch_ready), 32'(m_st[launch_wid] == 0));
         chk("busy", 32'(busy), 32'(m_busy()));
         if (fe_valid && ic_ready && !rst) dut_grants.push_back(int'(fe_wid));
      end
   end

   // Returns a next PC for every dispatched warp; drains when do_exit is set.
   task automatic service(input int max_cyc, input int want, input bit do_exit);
      bit          hs;
      logic [2:0]  hw;
      logic [31:0] hp, hm;
      for (int c = 0; c < max_cyc; c++) begin
         if (!do_exit && dut_grants.size() >= want) break;
         if (do_exit && !busy && !upd_valid) break;
         hs = fe_valid && ic_ready; hw = fe_wid; hp = fe_pc; hm = fe_mask;
         tick();
         upd_valid = hs; upd_wid = hw; upd_pc = hp + 32'd1; upd_mask = hm; upd_exit = do_exit;
      end
   endtask

   task automatic launch(input logic [2:0] w, input logic [31:0] pc);
      launch_valid = 1'b1; launch_wid = w; launch_pc = pc; launch_mask = 32'hFFFF_FFFF;
      tick();
      launch_valid = 1'b0;
   endtask

   task automatic retire(input logic [2:0] w);
      upd_valid = 1'b1; upd_wid = w; upd_pc = 32'h0; upd_mask = 32'hFFFF_FFFF; upd_exit = 1'b1;
      tick();
      upd_valid = 1'b0; upd_exit = 1'b0;
   endtask

   initial begin
      int          exp_rr[6];
      bit          hs;
      logic [2:0]  hw;
      logic [7:0]  disp;
      int          s;
      exp_rr = '{0, 1, 2, 0, 1, 2};

      rst = 1'b1; launch_valid = 1'b0; launch_wid = '0; launch_pc = '0; launch_mask = '0;
      ib_space = 8'hFF; ic_ready = 1'b0;
      upd_valid = 1'b0; upd_wid = '0; upd_pc = '0; upd_mask = '0; upd_exit = 1'b0;

      // Reset
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(fe_valid), 32'd0);
      chk("rst_pc", fe_pc, 32'd0);
      chk("rst_mask", fe_mask, 32'd0);
      chk("rst_wid", 32'(fe_wid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      for (int w = 0; w < 8; w++) begin
         launch_wid = 3'(w); #1;
         chk("rst_launch_ready", 32'(launch_ready), 32'd1);
      end

      // Single warp: request two edges after launch, parked until update
      ib_space = 8'hFF; ic_ready = 1'b1;
      launch(3'd3, 32'h100);
      chk("sw_not_yet", 32'(fe_valid), 32'd0);
      tick();
      chk("sw_valid", 32'(fe_valid), 32'd1);
      chk("sw_pc", fe_pc, 32'h100);
      chk("sw_wid", 32'(fe_wid), 32'd3);
      chk("sw_mask", fe_mask, 32'hFFFF_FFFF);
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sw_parked", 32'(fe_valid), 32'd0);
      end
      upd_valid = 1'b1; upd_wid = 3'd3; upd_pc = 32'h101; upd_mask = 32'hFFFF_FFFF; upd_exit = 1'b0;
      tick();
      upd_valid = 1'b0;
      chk("sw_upd_not_yet", 32'(fe_valid), 32'd0);
      tick();
      chk("sw_valid2", 32'(fe_valid), 32'd1);
      chk("sw_pc2", fe_pc, 32'h101);
      tick();
      retire(3'd3);
      launch_wid = 3'd3; #1;
      chk("sw_exit_busy", 32'(busy), 32'd0);
      chk("sw_exit_ready", 32'(launch_ready), 32'd1);

      // Round robin over warps 0,1,2
      ic_ready = 1'b0;
      launch(3'd0, 32'h0);
      launch(3'd1, 32'h40);
      launch(3'd2, 32'h80);
      dut_grants.delete();
      ic_ready = 1'b1;
      service(80, 6, 1'b0);
      chk("rr_count", 32'(dut_grants.size() >= 6), 32'd1);
      for (int i = 0; i < 6; i++) begin
         if (i < dut_grants.size()) chk("rr_order", 32'(dut_grants[i]), 32'(exp_rr[i]));
      end
      service(100, 0, 1'b1);
      chk("rr_drained", 32'(busy), 32'd0);

      // Backpressure with warp 1 pending
      ic_ready = 1'b0;
      launch(3'd1, 32'h200);
      tick();
      dut_grants.delete();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(fe_valid), 32'd1);
         chk("bp_pc", fe_pc, 32'h200);
         chk("bp_wid", 32'(fe_wid), 32'd1);
         tick();
      end
      chk("bp_no_hs", 32'(dut_grants.size()), 32'd0);
      ic_ready = 1'b1;
      repeat (3) tick();
      chk("bp_one_hs", 32'(dut_grants.size()), 32'd1);
      retire(3'd1);
      chk("bp_busy", 32'(busy), 32'd0);

      // Gating on ib_space, then exit
      ib_space = 8'hFB; ic_ready = 1'b1;
      dut_grants.delete();
      launch(3'd2, 32'h300);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("gate_idle", 32'(fe_valid), 32'd0);
      end
      chk("gate_no_grant", 32'(dut_grants.size()), 32'd0);
      ib_space = 8'hFF;
      tick();
      chk("gate_valid", 32'(fe_valid), 32'd1);
      chk("gate_wid", 32'(fe_wid), 32'd2);
      chk("gate_pc", fe_pc, 32'h300);
      tick();
      retire(3'd2);
      launch_wid = 3'd2; #1;
      chk("gate_exit_ready", 32'(launch_ready), 32'd1);
      chk("gate_exit_busy", 32'(busy), 32'd0);

      // Update to an inactive warp is dropped
      upd_valid = 1'b1; upd_wid = 3'd5; upd_pc = 32'h55; upd_mask = 32'hFFFF; upd_exit = 1'b0;
      tick();
      upd_valid = 1'b0;
      launch_wid = 3'd5; #1;
      chk("ill_ready", 32'(launch_ready), 32'd1);
      chk("ill_busy", 32'(busy), 32'd0);
      tick();
      chk("ill_no_req", 32'(fe_valid), 32'd0);

      // Reset while a request is pending
      ic_ready = 1'b0;
      launch(3'd4, 32'h400);
      tick();
      chk("mr_pending", 32'(fe_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_valid", 32'(fe_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      for (int w = 0; w < 8; w++) begin
         launch_wid = 3'(w); #1;
         chk("mr_launch_ready", 32'(launch_ready), 32'd1);
      end

      // Randomized traffic
      disp = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst          = ($urandom_range(0, 699) == 0);
         ib_space     = 8'($urandom | $urandom);
         ic_ready     = ($urandom_range(0, 3) != 0);
         launch_valid = ($urandom_range(0, 2) == 0);
         launch_wid   = 3'($urandom_range(0, 7));
         launch_pc    = $urandom;
         launch_mask  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
         upd_valid    = 1'b0;
         if (disp != 0 && $urandom_range(0, 1) == 1) begin
            s = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
               if (!upd_valid && disp[(s + k) % 8]) begin
                  upd_valid = 1'b1;
                  upd_wid   = 3'((s + k) % 8);
               end
            end
            disp[upd_wid] = 1'b0;
            upd_pc   = $urandom;
            upd_mask = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            upd_exit = ($urandom_range(0, 5) == 0);
         end
         hs = fe_valid && ic_ready && !rst;
         hw = fe_wid;
         tick();
         if (rst) disp = '0;
         else if (hs) disp[hw] = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/warp_fetcher.md
Name: warp_fetcher

Overview:
- Fetch stage directly upstream of the instruction cache.
- Holds a per-warp PC/active-mask table and selects one eligible warp per cycle with round-robin arbitration.
- Presents the selected warp's fetch request (pc, act_mask, warp_id) to the instruction cache over a valid/ready handshake.
- After dispatch, a warp is parked until the decode/branch path returns its next PC or retires it.

Parameters:
PcWidth, 32, program counter width
NumWarps, 8, warps per compute unit
WarpWidth, 32, threads per warp (active-mask width)
WidWidth, NumWarps>1 ? $clog2(NumWarps) : 1, derived warp-id width; do not override

Ports:
clk_i  in  1  clock; one clock; reset is synchronous and active-high
rst_i  in  1  synchronous active-high reset
launch_valid_i  in  1  warp launch request
launch_ready_o  out  1  launch accepted (target warp INACTIVE)
launch_wid_i  in  WidWidth  warp to launch
launch_pc_i  in  PcWidth  start PC
launch_act_mask_i  in  WarpWidth  initial active mask
ib_space_i  in  NumWarps  per-warp: downstream instruction buffer has a free slot
ic_ready_i  in  1  instruction cache accepts request
fe_valid_o  out  1  fetch request valid
fe_pc_o  out  PcWidth  fetch PC
fe_act_mask_o  out  WarpWidth  active mask
fe_warp_id_o  out  WidWidth  warp id
upd_valid_i  in  1  next-PC update from decode/branch unit
upd_wid_i  in  WidWidth  updated warp
upd_pc_i  in  PcWidth  next PC
upd_act_mask_i  in  WarpWidth  next active mask
upd_exit_i  in  1  warp terminated
busy_o  out  1  any warp not INACTIVE, or fe_valid_o high

Behaviour:
- Per-warp state: INACTIVE, READY, WAITING. Per-warp pc and act_mask registers.
- Reset (rst_i high at a clock edge):
  - all warps INACTIVE; pc and mask 0;
  - round-robin pointer 0 (warp 0 has highest priority first);
  - output register empty: fe_valid_o=0, fe_pc_o/fe_act_mask_o/fe_warp_id_o=0;
  - busy_o=0.
  - Reset mid-operation discards any pending request without a handshake.
- Launch:
  - launch_ready_o = (state[launch_wid_i]==INACTIVE), combinational.
  - On handshake the warp becomes READY at the next edge, loading pc and mask.
- Eligibility: state READY and ib_space_i[w]=1.
- Output register:
  - Loads when empty or when ic_ready_i && fe_valid_o in that cycle.
  - On load it takes the round-robin winner among eligible warps. The winner becomes WAITING in the same edge.
  - Round-robin pointer = winner+1 mod NumWarps.
  - If no warp is eligible, the register becomes empty.
- Handshake rules:
  - fe_valid_o and its payload stay stable until ic_ready_i.
  - fe_valid_o never depends combinationally on ic_ready_i.
  - Back-to-back issue is possible: 1 request/cycle.
- Latency: launch handshake at edge N -> READY after N -> fe_valid_o=1 after edge N+1 (with output empty and ib_space set).
- Update:
  - An update to a WAITING warp loads pc and mask at the next edge.
  - The warp becomes READY, or INACTIVE if upd_exit_i=1 or upd_act_mask_i==0.
  - An update to a non-WAITING warp is ignored; simulation assertion fires.
  - The updated warp is eligible for selection from the following cycle, not the same cycle.
- Simultaneous events:
  - Launch and update in the same cycle: both applied (they are necessarily to different warps).
  - Update and output load in the same cycle: independent.
- Removing ib_space_i after a warp is selected does not cancel the pending request.
- PC arithmetic: none inside the block. The next PC is always supplied via update; no wrap handling.

Test Plan:
- Reset:
  - Stimulus: rst_i high 2 cycles, then release.
  - Required: fe_valid_o=0, launch_ready_o=1 for any wid, busy_o=0.
- Single warp:
  - Stimulus: launch wid 3, pc 0x100, mask 0xFFFFFFFF; ic_ready_i=1; ib_space all 1.
  - Required: fe_valid_o high 2 cycles after launch with pc 0x100, wid 3, mask 0xFFFFFFFF.
  - Required: no further request until upd wid 3 pc 0x101. Then a request with pc 0x101.
- Round robin:
  - Stimulus: launch warps 0,1,2 (pc 0x0, 0x40, 0x80); ic_ready_i=1; after each dispatch, return update pc+1.
  - Required: grant order 0,1,2,0,1,2.
- Backpressure:
  - Stimulus: ic_ready_i=0 for 5 cycles with warp 1 pending.
  - Required: fe_valid_o, pc and wid stable all 5 cycles; exactly one handshake when ic_ready_i rises.
- Gating and exit:
  - Stimulus: ib_space_i[2]=0 with warp 2 READY.
  - Required: warp 2 is never selected. After ib_space_i[2]=1 it is selected.
  - Stimulus: update wid 2 with upd_exit_i=1.
  - Required: warp 2 INACTIVE, launch_ready_o=1 for wid 2, busy_o=0 when no other warp is active.
- Illegal update and mid-op reset:
  - Stimulus: update to an INACTIVE warp.
  - Required: ignored, assertion fires.
  - Stimulus: rst_i while fe_valid_o=1.
  - Required: fe_valid_o=0 next cycle, all warps INACTIVE.
